hazard_sched: RTL and testbench

- Pipeline hazard controller/scheduler for the 5-stage CPU. It sequences the IF/ID, ID_EX and EX_MEM pipeline registers around the EX stage.
- Detects RAW and load-use hazards, holds the pipeline for multi-cycle EX operations (multiply) and flushes on taken branches.
- Drives stall, bubble and flush enables consumed by the pipeline registers, plus forwarding selects for the EX operand muxes.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_sched_pkg.sv | 16 +
 rtl/hazard_sched_if.sv | 40 ++++
 rtl/hazard_sched_fwd_unit.sv | 29 ++
 rtl/hazard_sched.sv | 147 ++++++++++++++
 tb/tb_hazard_sched.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/hazard_sched_pkg.sv
// hazard_sched_pkg: shared constants and types for the hazard scheduler.
//   REG_W        register address width (SIZE = 32 -> 5 bits)
//   FWD_*        EX operand forwarding select encodings
//   state_t      scheduler FSM states
package hazard_sched_pkg;
  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef enum logic {
    RUN       = 1'b0,
    MULT_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/hazard_sched_if.sv
// hazard_sched_if: pipeline <-> hazard scheduler signal bundle.
//   master : pipeline side, drives stage info, receives stall/flush/forward controls
//   slave  : scheduler side
interface hazard_sched_if;
  import hazard_sched_pkg::*;

  // ID stage
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt;
  // EX stage
  logic             ex_valid;
  logic [REG_W-1:0] ex_rd, ex_rs, ex_rt;
  logic             ex_reg_write, ex_mem_read, ex_is_mult, ex_branch_taken;
  // MEM / WB producers
  logic [REG_W-1:0] mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  // controls
  logic             pc_stall, if_id_stall, if_id_flush;
  logic             id_ex_bubble, ex_hold, ex_mem_bubble;
  logic [1:0]       fwd_a_sel, fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_valid, ex_rd, ex_rs, ex_rt, ex_reg_write, ex_mem_read,
           ex_is_mult, ex_branch_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           ex_hold, ex_mem_bubble, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_valid, ex_rd, ex_rs, ex_rt, ex_reg_write, ex_mem_read,
           ex_is_mult, ex_branch_taken,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           ex_hold, ex_mem_bubble, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/hazard_sched_fwd_unit.sv
// fwd_unit: combinational EX operand forwarding selects.
//   in  : ex_rs/ex_rt (EX sources), mem_rd/mem_reg_write, wb_rd/wb_reg_write
//   out : fwd_a_sel, fwd_b_sel (FWD_RF / FWD_MEM / FWD_WB)
// MEM is the younger producer, so it wins over WB. r0 is never forwarded.
module fwd_unit
  import hazard_sched_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);
  function automatic logic [1:0] pick(logic [REG_W-1:0] src,
                                      logic [REG_W-1:0] m_rd, logic m_wr,
                                      logic [REG_W-1:0] w_rd, logic w_wr);
    if (m_wr && m_rd != '0 && m_rd == src) return FWD_MEM;
    if (w_wr && w_rd != '0 && w_rd == src) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_sel = pick(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b_sel = pick(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end
endmodule

// File: rtl/hazard_sched.sv
// hazard_sched: hazard controller for the 5-stage pipeline around EX.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : stage info in; pc_stall, if_id_stall, if_id_flush,
//                  id_ex_bubble, ex_hold, ex_mem_bubble, fwd_a/b_sel out
//   stall_count  : saturating count of cycles with pc_stall high
// Build option HAZARD_FWD_EN: enable operand forwarding, so only load-use
// stalls; without it any EX/MEM producer match stalls and selects are 0.
// A multiply stalls MULT_CYCLES-1 cycles: the detect cycle in RUN plus
// MULT_CYCLES-2 cycles in MULT_BUSY; EX retires it on the following cycle.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int SIZE        = 32,
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_sched_if.slave    bus,
  output logic [CNT_W-1:0] stall_count
);
  localparam int         ADDR_W    = $clog2(SIZE);
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 2);

  function automatic logic hit(logic wr, logic [ADDR_W-1:0] rd,
                               logic used, logic [ADDR_W-1:0] src);
    return wr && (rd != '0) && used && (rd == src);
  endfunction

  state_t     state, state_nx;
  logic [3:0] mult_cnt, mult_cnt_nx;
  logic       raw_hz;
  logic [1:0] fwd_a, fwd_b;

`ifdef HAZARD_FWD_EN
  // Forwarding covers ALU results; only a load in EX cannot be forwarded in time.
  always_comb
    raw_hz = bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
             (hit(bus.ex_reg_write, bus.ex_rd, bus.id_uses_rs, bus.id_rs) ||
              hit(bus.ex_reg_write, bus.ex_rd, bus.id_uses_rt, bus.id_rt));

  fwd_unit u_fwd (
    .ex_rs         (bus.ex_rs),
    .ex_rt         (bus.ex_rt),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .fwd_a_sel     (fwd_a),
    .fwd_b_sel     (fwd_b)
  );
`else
  // No bypass: wait until the producer reaches WB (regfile is write-first).
  logic fwd_unused;
  assign fwd_unused = ^{bus.ex_rs, bus.ex_rt, bus.wb_rd, bus.wb_reg_write,
                        bus.ex_mem_read};

  always_comb
    raw_hz = bus.id_valid &&
             ((bus.ex_valid &&
               (hit(bus.ex_reg_write, bus.ex_rd, bus.id_uses_rs, bus.id_rs) ||
                hit(bus.ex_reg_write, bus.ex_rd, bus.id_uses_rt, bus.id_rt))) ||
              hit(bus.mem_reg_write, bus.mem_rd, bus.id_uses_rs, bus.id_rs) ||
              hit(bus.mem_reg_write, bus.mem_rd, bus.id_uses_rt, bus.id_rt));

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      mult_cnt <= '0;
    end else begin
      state    <= state_nx;
      mult_cnt <= mult_cnt_nx;
    end
  end

  // next state: mult_cnt holds the MULT_BUSY cycles still to go
  always_comb begin
    state_nx    = state;
    mult_cnt_nx = mult_cnt;
    case (state)
      RUN: begin
        if (bus.ex_valid && !bus.ex_branch_taken && bus.ex_is_mult) begin
          mult_cnt_nx = MULT_LOAD;
          if (MULT_CYCLES > 2) state_nx = MULT_BUSY;
        end
      end
      MULT_BUSY: begin
        mult_cnt_nx = mult_cnt - 4'd1;
        if (mult_cnt <= 4'd1) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // outputs: branch flush beats any stall since the ID instruction is dead
  always_comb begin
    bus.pc_stall      = 1'b0;
    bus.if_id_stall   = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_hold       = 1'b0;
    bus.ex_mem_bubble = 1'b0;
    bus.fwd_a_sel     = FWD_RF;
    bus.fwd_b_sel     = FWD_RF;
    if (rst_n) begin
      bus.fwd_a_sel = fwd_a;
      bus.fwd_b_sel = fwd_b;
      case (state)
        RUN: begin
          if (bus.ex_valid && bus.ex_branch_taken) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
          end else if (bus.ex_valid && bus.ex_is_mult) begin
            bus.pc_stall      = 1'b1;
            bus.if_id_stall   = 1'b1;
            bus.ex_hold       = 1'b1;
            bus.ex_mem_bubble = 1'b1;
          end else if (raw_hz) begin
            bus.pc_stall     = 1'b1;
            bus.if_id_stall  = 1'b1;
            bus.id_ex_bubble = 1'b1;
          end
        end
        MULT_BUSY: begin
          bus.pc_stall      = 1'b1;
          bus.if_id_stall   = 1'b1;
          bus.ex_hold       = 1'b1;
          bus.ex_mem_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // saturating stall counter
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_count <= '0;
    else if (bus.pc_stall && stall_count != '1)
      stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed vector bench for hazard_sched (MULT_CYCLES = 4,
// 4-bit stall counter so saturation is reachable). Expected control word
// is {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble}.
module tb_hazard_sched;
  import hazard_sched_pkg::*;

  localparam int         CW    = 4;
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110100;
  localparam logic [5:0] FLUSH = 6'b001100;
  localparam logic [5:0] MULT  = 6'b110011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] exp_cnt;
  int            n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  hazard_sched_if bus ();

  hazard_sched #(.SIZE(32), .MULT_CYCLES(4), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .stall_count (stall_count)
  );

  typedef struct {
    string      nm;
    logic [4:0] id_rs, id_rt;
    logic       urs, urt;
    logic [4:0] ex_rd;
    logic       ex_rw, ex_mr, br;
    logic [4:0] ex_rs, ex_rt, mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic [5:0] ectl;
    logic [1:0] ea, eb;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
            bus.id_ex_bubble, bus.ex_hold, bus.ex_mem_bubble};
  endfunction

  task automatic idle();
    bus.id_valid = 1'b1; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_rd = '0; bus.ex_rs = '0; bus.ex_rt = '0;
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0;
    bus.ex_is_mult = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_rd = '0; bus.mem_reg_write = 1'b0;
    bus.wb_rd = '0; bus.wb_reg_write = 1'b0;
  endtask

  // load writing r4 in EX, ID reads r4: stalls in either build
  task automatic stall_vec();
    idle();
    bus.ex_rd = 5'd4; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
    bus.id_rt = 5'd4; bus.id_uses_rt = 1'b1;
  endtask

  // called right after inputs change at a falling edge
  task automatic look(string nm, logic [5:0] ectl, logic [1:0] ea, logic [1:0] eb);
    #1;
    chk({nm, ".ctl"}, 8'(ctl_now()), 8'(ectl));
    chk({nm, ".fwd_a"}, 8'(bus.fwd_a_sel), 8'(ea));
    chk({nm, ".fwd_b"}, 8'(bus.fwd_b_sel), 8'(eb));
    chk({nm, ".cnt"}, 8'(stall_count), 8'(exp_cnt));
    if (ectl[5] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
`ifdef HAZARD_FWD_EN
    tbl[0] = '{"loaduse",     8,0,1,0, 8,1,1,0, 0,0, 0,0, 0,0, STALL, 0,0};
    tbl[1] = '{"alu_nostall", 8,0,1,0, 8,1,0,0, 0,0, 0,0, 0,0, NONE,  0,0};
    tbl[2] = '{"mem_nostall", 0,4,0,1, 0,0,0,0, 0,0, 4,1, 0,0, NONE,  0,0};
    tbl[3] = '{"fwd_mem_pri", 0,0,0,0, 0,0,0,0, 8,6, 8,1, 8,1, NONE,  1,0};
    tbl[4] = '{"fwd_wb",      0,0,0,0, 0,0,0,0, 8,6, 0,1, 8,1, NONE,  2,0};
    tbl[5] = '{"fwd_b_mem",   0,0,0,0, 0,0,0,0, 8,6, 6,1, 8,1, NONE,  2,1};
    tbl[6] = '{"fwd_r0",      0,0,0,0, 0,0,0,0, 0,0, 0,1, 0,1, NONE,  0,0};
    tbl[7] = '{"br_over_lu",  8,0,1,0, 8,1,1,1, 0,0, 0,0, 0,0, FLUSH, 0,0};
`else
    tbl[0] = '{"raw_ex",      0,4,0,1, 4,1,0,0, 0,0, 0,0, 0,0, STALL, 0,0};
    tbl[1] = '{"raw_mem",     0,4,0,1, 0,0,0,0, 0,0, 4,1, 0,0, STALL, 0,0};
    tbl[2] = '{"wb_only",     0,4,0,1, 0,0,0,0, 0,0, 0,0, 4,1, NONE,  0,0};
    tbl[3] = '{"rd_zero",     0,0,0,1, 0,1,0,0, 0,0, 0,1, 0,0, NONE,  0,0};
    tbl[4] = '{"uses_off",    0,4,0,0, 4,1,0,0, 0,0, 0,0, 0,0, NONE,  0,0};
    tbl[5] = '{"rw_off",      0,4,0,1, 4,0,0,0, 0,0, 4,0, 0,0, NONE,  0,0};
    tbl[6] = '{"raw_rs",      9,0,1,0, 9,1,0,0, 0,0, 0,0, 0,0, STALL, 0,0};
    tbl[7] = '{"br_over_raw", 0,4,0,1, 4,1,0,1, 0,0, 0,0, 0,0, FLUSH, 0,0};
`endif

    // reset held two edges with a multiply and a forwardable producer present
    exp_cnt = '0;
    rst_n = 1'b0;
    stall_vec();
    bus.ex_is_mult = 1'b1;
    bus.ex_rs = 5'd4; bus.mem_rd = 5'd4; bus.mem_reg_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    look("reset", NONE, 2'd0, 2'd0);

    // release: multiply detected, then MULT_BUSY ignores hazard and branch
    @(negedge clk); rst_n = 1'b1; idle(); bus.ex_is_mult = 1'b1;
    look("mult_go", MULT, 2'd0, 2'd0);
    @(negedge clk); stall_vec(); bus.ex_branch_taken = 1'b1;
    look("mult_busy1", MULT, 2'd0, 2'd0);
    @(negedge clk);
    look("mult_busy2", MULT, 2'd0, 2'd0);
    @(negedge clk); idle();
    look("mult_done", NONE, 2'd0, 2'd0);

    // table
    foreach (tbl[i]) begin
      @(negedge clk);
      idle();
      bus.id_rs = tbl[i].id_rs; bus.id_rt = tbl[i].id_rt;
      bus.id_uses_rs = tbl[i].urs; bus.id_uses_rt = tbl[i].urt;
      bus.ex_rd = tbl[i].ex_rd; bus.ex_reg_write = tbl[i].ex_rw;
      bus.ex_mem_read = tbl[i].ex_mr; bus.ex_branch_taken = tbl[i].br;
      bus.ex_rs = tbl[i].ex_rs; bus.ex_rt = tbl[i].ex_rt;
      bus.mem_rd = tbl[i].mem_rd; bus.mem_reg_write = tbl[i].mem_rw;
      bus.wb_rd = tbl[i].wb_rd; bus.wb_reg_write = tbl[i].wb_rw;
      look(tbl[i].nm, tbl[i].ectl, tbl[i].ea, tbl[i].eb);
    end

    // fill the counter to all-ones (bounded by counter width)
    for (int k = 0; k < 16 && exp_cnt != '1; k++) begin
      @(negedge clk); stall_vec();
      look("sat_fill", STALL, 2'd0, 2'd0);
    end
    @(negedge clk); stall_vec();
    look("sat_stall", STALL, 2'd0, 2'd0);
    @(negedge clk); stall_vec(); bus.ex_branch_taken = 1'b1;
    look("sat_branch", FLUSH, 2'd0, 2'd0);
    @(negedge clk); idle();
    look("sat_hold", NONE, 2'd0, 2'd0);

    // reset in the middle of MULT_BUSY lands in RUN
    @(negedge clk); idle(); bus.ex_is_mult = 1'b1;
    look("mult2_go", MULT, 2'd0, 2'd0);
    @(negedge clk); idle();
    look("mult2_busy", MULT, 2'd0, 2'd0);
    @(negedge clk); rst_n = 1'b0;
    look("rst_in_busy", NONE, 2'd0, 2'd0);
    @(negedge clk); rst_n = 1'b1; exp_cnt = '0;
    look("post_rst_run", NONE, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
